// File: rtl/button_event_decoder.sv
// Turns a debounced pushbutton level into press/release/long-press pulses
// and a multi-click report issued once the inter-click gap expires.
module button_event_decoder #(
    parameter bit ACTIVE_LOW  = 1'b1,
    parameter int LONG_CYCLES = 25000000,
    parameter int GAP_CYCLES  = 12500000,
    parameter int MAX_CLICKS  = 3,
    parameter int CLICK_W     = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pb_state,
    output logic               press_pulse,
    output logic               release_pulse,
    output logic               long_press,
    output logic               held,
    output logic               click_valid,
    output logic [CLICK_W-1:0] click_count
);

    localparam int TMAX = (LONG_CYCLES > GAP_CYCLES) ? LONG_CYCLES : GAP_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);
    localparam logic [TW-1:0]      LONG_LAST = TW'(LONG_CYCLES - 1);
    localparam logic [TW-1:0]      GAP_LAST  = TW'(GAP_CYCLES - 1);
    localparam logic [CLICK_W:0]   MAX_C     = (CLICK_W + 1)'(MAX_CLICKS);

    typedef enum logic [1:0] {IDLE, PRESSED, LONG_HELD, GAP} state_t;

    state_t               state_q, state_d;
    logic [TW-1:0]        timer_q, timer_d, timer_inc;
    logic [CLICK_W-1:0]   clicks_q, clicks_d;
    logic [CLICK_W:0]     clicks_inc;
    logic                 prev_q;
    logic                 press_q, press_d;
    logic                 release_q, release_d;
    logic                 long_q, long_d;
    logic                 held_q;
    logic                 cv_q, cv_d;
    logic [CLICK_W-1:0]   cc_q, cc_d;

    logic pressed_in, press_edge, release_edge;

    assign pressed_in   = (pb_state == ~ACTIVE_LOW);
    assign press_edge   = pressed_in & ~prev_q;
    assign release_edge = ~pressed_in & prev_q;
    // Saturating increment; the timer must never wrap back into a match.
    assign timer_inc    = (timer_q == {TW{1'b1}}) ? timer_q : timer_q + TW'(1);
    assign clicks_inc   = {1'b0, clicks_q} + (CLICK_W + 1)'(1);

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        clicks_d  = clicks_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        long_d    = 1'b0;
        cv_d      = 1'b0;
        cc_d      = cc_q;
        case (state_q)
            IDLE: begin
                if (press_edge) begin
                    state_d = PRESSED;
                    press_d = 1'b1;
                    timer_d = '0;
                end
            end
            PRESSED: begin
                // Release is tested first so it beats a coincident long-press.
                if (release_edge) begin
                    release_d = 1'b1;
                    timer_d   = '0;
                    if (clicks_inc == MAX_C) begin
                        cv_d     = 1'b1;
                        cc_d     = CLICK_W'(MAX_CLICKS);
                        clicks_d = '0;
                        state_d  = IDLE;
                    end else begin
                        clicks_d = clicks_inc[CLICK_W-1:0];
                        state_d  = GAP;
                    end
                end else if (timer_q == LONG_LAST) begin
                    state_d  = LONG_HELD;
                    long_d   = 1'b1;
                    clicks_d = '0;
                    timer_d  = '0;
                end else begin
                    timer_d = timer_inc;
                end
            end
            LONG_HELD: begin
                if (release_edge) begin
                    release_d = 1'b1;
                    state_d   = IDLE;
                    timer_d   = '0;
                end
            end
            GAP: begin
                // Press is tested first so it beats a coincident gap timeout.
                if (press_edge) begin
                    press_d = 1'b1;
                    state_d = PRESSED;
                    timer_d = '0;
                end else if (timer_q == GAP_LAST) begin
                    cv_d     = 1'b1;
                    cc_d     = clicks_q;
                    clicks_d = '0;
                    state_d  = IDLE;
                    timer_d  = '0;
                end else begin
                    timer_d = timer_inc;
                end
            end
            default: begin
                state_d = IDLE;
                timer_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            clicks_q  <= '0;
            prev_q    <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
            held_q    <= 1'b0;
            cv_q      <= 1'b0;
            cc_q      <= '0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            clicks_q  <= clicks_d;
            prev_q    <= pressed_in;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
            held_q    <= pressed_in;
            cv_q      <= cv_d;
            cc_q      <= cc_d;
        end
    end

    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign long_press    = long_q;
    assign held          = held_q;
    assign click_valid   = cv_q;
    assign click_count   = cc_q;

endmodule

// File: tb/tb_button_event_decoder.sv
// Directed bench for button_event_decoder with LONG=8, GAP=5, MAX_CLICKS=3;
// event cycles are counted from the first edge of each scenario.
module tb_button_event_decoder;

    logic       clk = 1'b0;
    logic       rst;
    logic       pb_state;
    logic       press_pulse, release_pulse, long_press, held, click_valid;
    logic [1:0] click_count;

    button_event_decoder #(
        .ACTIVE_LOW (1'b1),
        .LONG_CYCLES(8),
        .GAP_CYCLES (5),
        .MAX_CLICKS (3),
        .CLICK_W    (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pb_state     (pb_state),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .long_press   (long_press),
        .held         (held),
        .click_valid  (click_valid),
        .click_count  (click_count)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int cyc;
    int n_press, n_rel, n_long, n_cv, n_held, n_both;
    int press_at, rel_at, long_at, cv_at, cv_cnt;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    task automatic clr();
        cyc = 0;
        n_press = 0; n_rel = 0; n_long = 0; n_cv = 0; n_held = 0; n_both = 0;
        press_at = -1; rel_at = -1; long_at = -1; cv_at = -1; cv_cnt = -1;
    endtask

    // pb: 0 = pressed (active low). Outputs sampled 1 time unit after the edge.
    task automatic tick(input logic v);
        pb_state = v;
        @(posedge clk);
        #1;
        cyc++;
        if (press_pulse)   begin n_press++; press_at = cyc; end
        if (release_pulse) begin n_rel++;   rel_at   = cyc; end
        if (long_press)    begin n_long++;  long_at  = cyc; end
        if (click_valid)   begin n_cv++;    cv_at    = cyc; cv_cnt = int'(click_count); end
        if (held) n_held++;
        if (press_pulse && release_pulse) n_both++;
    endtask

    task automatic run(input logic v, input int n);
        for (int i = 0; i < n; i++) tick(v);
    endtask

    initial begin
        rst = 1'b1;
        pb_state = 1'b1;
        clr();
        run(1'b1, 3);
        chk("rst_press",   int'(press_pulse), 0);
        chk("rst_release", int'(release_pulse), 0);
        chk("rst_long",    int'(long_press), 0);
        chk("rst_held",    int'(held), 0);
        chk("rst_cv",      int'(click_valid), 0);
        chk("rst_cc",      int'(click_count), 0);
        rst = 1'b0;
        run(1'b1, 2);

        // single click
        clr();
        run(1'b0, 3); run(1'b1, 12);
        chk("s1_press_at", press_at, 1);
        chk("s1_rel_at",   rel_at, 4);
        chk("s1_cv_at",    cv_at, 9);
        chk("s1_cv_cnt",   cv_cnt, 1);
        chk("s1_n_cv",     n_cv, 1);
        chk("s1_n_long",   n_long, 0);
        chk("s1_n_held",   n_held, 3);

        // double click
        clr();
        run(1'b0, 3); run(1'b1, 2); run(1'b0, 3); run(1'b1, 12);
        chk("s2_n_press", n_press, 2);
        chk("s2_rel_at",  rel_at, 9);
        chk("s2_cv_at",   cv_at, 14);
        chk("s2_cv_cnt",  cv_cnt, 2);
        chk("s2_n_cv",    n_cv, 1);

        // long press
        clr();
        run(1'b0, 20); run(1'b1, 12);
        chk("s3_press_at", press_at, 1);
        chk("s3_long_at",  long_at, 9);
        chk("s3_n_long",   n_long, 1);
        chk("s3_n_held",   n_held, 20);
        chk("s3_rel_at",   rel_at, 21);
        chk("s3_n_cv",     n_cv, 0);

        // triple click reported with third release
        clr();
        run(1'b0, 2); run(1'b1, 2); run(1'b0, 2); run(1'b1, 2); run(1'b0, 2); run(1'b1, 10);
        chk("s4_rel_at",  rel_at, 11);
        chk("s4_cv_at",   cv_at, 11);
        chk("s4_cv_cnt",  cv_cnt, 3);
        chk("s4_n_cv",    n_cv, 1);
        // back in IDLE: a fresh click reports count 1
        clr();
        run(1'b0, 1); run(1'b1, 10);
        chk("s4_next_cv_at",  cv_at, 7);
        chk("s4_next_cv_cnt", cv_cnt, 1);

        // release on the long-press edge: release wins
        clr();
        run(1'b0, 8); run(1'b1, 10);
        chk("s5a_n_long", n_long, 0);
        chk("s5a_rel_at", rel_at, 9);
        chk("s5a_cv_at",  cv_at, 14);
        chk("s5a_cv_cnt", cv_cnt, 1);

        // one cycle longer: long press, no click
        clr();
        run(1'b0, 9); run(1'b1, 10);
        chk("s5b_long_at", long_at, 9);
        chk("s5b_rel_at",  rel_at, 10);
        chk("s5b_n_cv",    n_cv, 0);

        // press on the gap-timeout edge: press wins
        clr();
        run(1'b0, 2); run(1'b1, 5); run(1'b0, 2); run(1'b1, 10);
        chk("s5c_press_at", press_at, 8);
        chk("s5c_n_cv",     n_cv, 1);
        chk("s5c_cv_at",    cv_at, 15);
        chk("s5c_cv_cnt",   cv_cnt, 2);

        // reset mid-sequence with button held across deassert
        clr();
        run(1'b0, 2); run(1'b1, 2);
        rst = 1'b1;
        run(1'b0, 2);
        chk("s6_press",   int'(press_pulse), 0);
        chk("s6_release", int'(release_pulse), 0);
        chk("s6_held",    int'(held), 0);
        chk("s6_cv",      int'(click_valid), 0);
        chk("s6_cc",      int'(click_count), 0);
        rst = 1'b0;
        run(1'b0, 2); run(1'b1, 12);
        chk("s6_press_at", press_at, 7);
        chk("s6_n_cv",     n_cv, 1);
        chk("s6_cv_at",    cv_at, 14);
        chk("s6_cv_cnt",   cv_cnt, 1);

        chk("pulse_overlap", n_both, 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
